uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning cycles allowed in WAIT_BUSY before abort (1..255).
REQ-003 SHALL have port pclk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port prstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  grant enable; 0 blocks new grants only.
REQ-006 SHALL have port req  input  NREQ  per-requester byte-pending level.
REQ-007 SHALL have port req_data  input  NREQ*8  byte of requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_ack  output  NREQ  one-cycle pulse: byte of requester i accepted.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte presented to the transmitter; stable from grant until the return to IDLE.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy level.
REQ-012 SHALL have port grant_id  output  clog2(NREQ)  index of the last granted requester.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on abort.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-015 In IDLE with en=1 and req!=0 at an edge, SHALL select the winner, latch its byte into tx_data, set grant_id, pulse req_ack[winner] and enter START on that edge.
REQ-016 Winner SHALL be the first set req bit searching upward from grant_id+1, wrapping modulo NREQ (round-robin).
REQ-017 In START, SHALL pulse tx_start for exactly one cycle, clear the timeout counter and enter WAIT_BUSY.
REQ-018 Latency SHALL be: req_ack one cycle after the sampling edge; tx_start one cycle after req_ack.
REQ-019 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE; otherwise the 8-bit counter SHALL increment.
REQ-020 When the counter equals TIMEOUT in WAIT_BUSY, SHALL pulse timeout_err and return to IDLE; the byte SHALL be dropped, with no retry.
REQ-021 In WAIT_DONE, tx_busy=0 SHALL return the FSM to IDLE; there is no timeout in this state.
REQ-022 req SHALL be sampled only in IDLE; changes to req or req_data in other states SHALL be ignored.
REQ-023 A requester SHALL deassert req or present its next byte on the cycle after req_ack; a held req means a new byte.
REQ-024 en falling during a transfer SHALL NOT abort it; the FSM completes to IDLE and then idles.
REQ-025 A single requester with continuous req SHALL be granted on every IDLE visit.
REQ-026 With simultaneous requests, no requester SHALL wait more than NREQ-1 grants.
REQ-027 At most one req_ack bit SHALL be set in any cycle.

Reset
REQ-028 prstn=0 SHALL asynchronously force state=IDLE, req_ack=0, tx_start=0, tx_data=0, timeout_err=0, counter=0.
REQ-029 prstn=0 SHALL force grant_id=NREQ-1 so that requester 0 has first priority.
REQ-030 Reset mid-transfer SHALL abandon the byte without issuing ack, start or error pulses after release.

Structure
REQ-031 State encoding and default NREQ/TIMEOUT SHALL live in shared package uart_pkg.
REQ-032 The round-robin selector SHALL be a combinational sub-module rr_pick(req, last) -> (valid, idx); the FSM stays in uart_tx_arb.

Verification
REQ-033 Verify: req=4'b0001, data 8'hA0, model tx_busy high 2 cycles after tx_start for 20 cycles -> req_ack=0001 at +1, tx_start at +2, tx_data=8'hA0, back in IDLE after busy falls.
REQ-034 Verify: req=4'b1111 held, data A0/B1/C2/D3 -> grant order 0,1,2,3,0; each req_ack one-hot.
REQ-035 Verify: tx_busy tied 0, single request -> timeout_err pulse exactly TIMEOUT+1 cycles after tx_start, FSM in IDLE, no further ack for that byte.
REQ-036 Verify: en=0 with req=4'b0100 -> no req_ack for 50 cycles; en=1 -> grant to requester 2 next cycle.
REQ-037 Verify: prstn low during WAIT_DONE -> all outputs 0 immediately, grant_id=NREQ-1; after release with req=4'b1001, requester 0 is granted first.
REQ-038 Verify: grant_id=1, req=4'b0011 -> requester 0 is granted (wrap past 3).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and default parameters for the UART transmit arbiter.
package uart_pkg;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 255;
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit searching upward from last+1 with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    logic [IW-1:0] w_pos;
    always_comb begin
        valid = |req;
        idx   = last;
        w_pos = last;
        // scan from the farthest candidate down so the nearest one after last wins
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = IW'((int'(last) + k) % NREQ);
            if (req[w_pos]) idx = w_pos;
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding bytes from NREQ requesters to a single UART transmitter.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      pclk,
    input  logic                      prstn,
    input  logic                      en,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*8-1:0]         req_data,
    output logic [NREQ-1:0]           req_ack,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      timeout_err
);
    localparam int IW = $clog2(NREQ);
    state_t        r_state;
    logic [7:0]    r_cnt;
    logic          w_valid;
    logic [IW-1:0] w_idx;
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .last  (grant_id),
        .valid (w_valid),
        .idx   (w_idx)
    );
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            timeout_err <= 1'b0;
            grant_id    <= IW'(NREQ - 1);
        end else begin
            req_ack     <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: if (en && w_valid) begin
                    tx_data  <= req_data[{w_idx, 3'b000} +: 8];
                    grant_id <= w_idx;
                    req_ack  <= NREQ'(1) << w_idx;
                    r_state  <= START;
                end
                START: begin
                    tx_start <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    r_state <= WAIT_DONE;
                end else if (r_cnt == 8'(TIMEOUT)) begin
                    timeout_err <= 1'b1;
                    r_state     <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                WAIT_DONE: if (!tx_busy) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized self-checking bench with a round-robin reference model and transmitter model.
module tb_uart_tx_arb;
    localparam int N = 4;
    localparam int T = 40;
    logic           pclk = 1'b0;
    logic           prstn = 1'b0;
    logic           en = 1'b0;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;
    logic           timeout_err;
    int errors = 0;
    int checks = 0;
    int last_id = N - 1;
    int seq[5] = '{0, 1, 2, 3, 0};
    uart_tx_arb #(.NREQ(N), .TIMEOUT(T)) dut (
        .pclk        (pclk),
        .prstn       (prstn),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );
    always #5 pclk = ~pclk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int rr(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction
    task automatic grant(input logic [N-1:0] r, input logic [N*8-1:0] d);
        int w;
        w = rr(last_id, r);
        req = r;
        req_data = d;
        en = 1'b1;
        @(negedge pclk);
        chk("ack", 32'(req_ack), 32'(1) << w);
        chk("tx_data", 32'(tx_data), 32'(d[w*8 +: 8]));
        chk("grant_id", 32'(grant_id), 32'(w));
        last_id = w;
        req = N'($urandom);
        req_data = N*8'($urandom);
    endtask
    task automatic finish(input int dly, input int len);
        @(negedge pclk);
        chk("tx_start", 32'({req_ack, tx_start}), 32'd1);
        en = 1'($urandom);
        repeat (dly) begin
            @(negedge pclk);
            chk("wait_quiet", 32'({req_ack, tx_start, timeout_err}), 32'd0);
        end
        tx_busy = 1'b1;
        repeat (len) begin
            @(negedge pclk);
            chk("busy_quiet", 32'({req_ack, tx_start, timeout_err}), 32'd0);
        end
        tx_busy = 1'b0;
        @(negedge pclk);
        chk("idle_quiet", 32'({req_ack, tx_start, timeout_err}), 32'd0);
    endtask
    initial begin
        logic [N-1:0] acc;
        repeat (2) @(negedge pclk);
        chk("rst_outs", 32'({req_ack, tx_start, tx_data, timeout_err}), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'(N - 1));
        prstn = 1'b1;
        @(negedge pclk);
        for (int i = 0; i < 5; i++) begin
            grant(4'b1111, 32'hD3C2B1A0);
            chk("rr_order", 32'(grant_id), 32'(seq[i]));
            finish($urandom_range(0, 4), $urandom_range(1, 4));
        end
        grant(4'b0001, 32'h000000A0);
        chk("first_byte", 32'(tx_data), 32'hA0);
        finish(2, 20);
        grant(4'b0010, 32'h00005500);
        finish(1, 2);
        grant(4'b0011, 32'h00006677);
        chk("wrap", 32'(grant_id), 32'd0);
        finish(0, 1);
        en = 1'b0;
        req = 4'b0100;
        acc = '0;
        repeat (50) begin
            @(negedge pclk);
            acc |= req_ack;
        end
        chk("en_block", 32'(acc), 32'd0);
        grant(4'b0100, 32'h00990000);
        finish(3, 3);
        grant(4'b1000, 32'h5A000000);
        req = '0;
        @(negedge pclk);
        chk("to_start", 32'(tx_start), 32'd1);
        repeat (T) begin
            @(negedge pclk);
            chk("to_wait", 32'({req_ack, tx_start, timeout_err}), 32'd0);
        end
        @(negedge pclk);
        chk("to_pulse", 32'(timeout_err), 32'd1);
        repeat (3) begin
            @(negedge pclk);
            chk("to_after", 32'({req_ack, tx_start, timeout_err}), 32'd0);
        end
        grant(4'b0001, 32'h000000C3);
        req = '0;
        @(negedge pclk);
        tx_busy = 1'b1;
        repeat (2) @(negedge pclk);
        #2 prstn = 1'b0;
        #1;
        chk("arst_outs", 32'({req_ack, tx_start, tx_data, timeout_err}), 32'd0);
        chk("arst_gid", 32'(grant_id), 32'(N - 1));
        @(negedge pclk);
        prstn = 1'b1;
        tx_busy = 1'b0;
        last_id = N - 1;
        repeat (2) begin
            @(negedge pclk);
            chk("post_rst", 32'({req_ack, tx_start, timeout_err}), 32'd0);
        end
        grant(4'b1001, 32'h44000011);
        chk("rst_first", 32'(grant_id), 32'd0);
        finish(1, 2);
        for (int i = 0; i < 30; i++) begin
            grant(N'($urandom_range(1, 15)), N*8'($urandom));
            finish($urandom_range(0, 8), $urandom_range(1, 5));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
